// File: rtl/demux_1to2_buf.sv
// demux_1to2_buf: steers a select-tagged valid/ready stream into two per-channel FIFOs; optional counters via DEMUX_CNT_EN.
// Latency: one cycle from input accept to out*_valid when the target FIFO was empty; no pass-through path.
// Backpressure: in_ready = ~full of the FIFO picked by in_sel; a full channel stalls the input only while selected.

module demux_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    // Generic circular FIFO with extra-MSB pointers; head is the word at rd_ptr.
    // Latency: a pushed word is visible at head one edge later if empty.
    // Backpressure: caller must not push when full nor pop when empty.

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

module demux_1to2_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sel,
    input  logic [W-1:0] in_data,
    output logic         out0_valid,
    input  logic         out0_ready,
    output logic [W-1:0] out0_data,
    output logic         out1_valid,
    input  logic         out1_ready,
    output logic [W-1:0] out1_data
`ifdef DEMUX_CNT_EN
    ,
    output logic [7:0]   cnt0,
    output logic [7:0]   cnt1
`endif
);
    generate
        if (W < 1 || DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
            $error("demux_1to2_buf: W must be >= 1 and DEPTH a power of two in 2..16");
        end
    endgenerate

    logic full0;
    logic full1;
    logic empty0;
    logic empty1;
    logic accept;
    logic push0;
    logic push1;
    logic pop0;
    logic pop1;

    // Ready looks only at the selected FIFO, never at in_valid.
    assign in_ready = in_sel ? ~full1 : ~full0;
    assign accept   = in_valid & in_ready;
    assign push0    = accept & ~in_sel;
    assign push1    = accept & in_sel;

    assign out0_valid = ~empty0;
    assign out1_valid = ~empty1;
    assign pop0       = out0_valid & out0_ready;
    assign pop1       = out1_valid & out1_ready;

    demux_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .push_data (in_data),
        .pop       (pop0),
        .full      (full0),
        .empty     (empty0),
        .head      (out0_data)
    );

    demux_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_data (in_data),
        .pop       (pop1),
        .full      (full1),
        .empty     (empty1),
        .head      (out1_data)
    );

`ifdef DEMUX_CNT_EN
    // Counted at accept time and saturating, so they reflect link traffic, not consumption.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= 8'h00;
            cnt1 <= 8'h00;
        end else begin
            if (push0 && cnt0 != 8'hFF) begin
                cnt0 <= cnt0 + 8'd1;
            end
            if (push1 && cnt1 != 8'hFF) begin
                cnt1 <= cnt1 + 8'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_demux_1to2_buf.sv
// Bench for demux_1to2_buf: per-scenario tasks plus a per-channel scoreboard of accepted words.
module tb_demux_1to2_buf;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_sel;
    logic [7:0] in_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out0_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out1_data;
`ifdef DEMUX_CNT_EN
    logic [7:0] cnt0;
    logic [7:0] cnt1;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int rx0 = 0;
    int rx1 = 0;
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    logic [7:0] e0;
    logic [7:0] e1;

    always #5 clk = ~clk;

    demux_1to2_buf #(.W(8), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    // Scoreboard: handshakes are evaluated mid-low-phase, ahead of the edge that commits them.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            exp0.delete();
            exp1.delete();
        end else begin
            if (out0_valid && out0_ready) begin
                tests_run++;
                rx0++;
                if (exp0.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_ch0_extra: got %h, required no word", out0_data);
                end else begin
                    e0 = exp0.pop_front();
                    if (out0_data !== e0) begin
                        tests_failed++;
                        $display("FAIL sb_ch0_data: got %h, required %h", out0_data, e0);
                    end
                end
            end
            if (out1_valid && out1_ready) begin
                tests_run++;
                rx1++;
                if (exp1.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_ch1_extra: got %h, required no word", out1_data);
                end else begin
                    e1 = exp1.pop_front();
                    if (out1_data !== e1) begin
                        tests_failed++;
                        $display("FAIL sb_ch1_data: got %h, required %h", out1_data, e1);
                    end
                end
            end
            if (in_valid && in_ready) begin
                if (in_sel) exp1.push_back(in_data);
                else        exp0.push_back(in_data);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the word was accepted.
    task automatic send(input logic s, input logic [7:0] d);
        bit ok = 0;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        for (int n = 0; n < 60; n++) begin
            #1;
            if (in_ready === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL send_timeout: word %h sel %0d never accepted, in_ready=%b", d, s, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            #3;
            if (exp0.size() == 0 && exp1.size() == 0 && out0_valid === 1'b0 && out1_valid === 1'b0) begin
                ok = 1;
                break;
            end
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL drain_timeout: pending ch0=%0d ch1=%0d, required 0", exp0.size(), exp1.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = 8'h00;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        #3;
        tests_run++;
        if ({in_ready, out0_valid, out1_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_flags: in_ready/out0_valid/out1_valid=%b, required 100",
                     {in_ready, out0_valid, out1_valid});
        end
        tests_run++;
        if (out0_data !== 8'h00 || out1_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_data: out0=%h out1=%h, required 00 00", out0_data, out1_data);
        end
`ifdef DEMUX_CNT_EN
        tests_run++;
        if (cnt0 !== 8'h00 || cnt1 !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_cnt: cnt0=%h cnt1=%h, required 00 00", cnt0, cnt1);
        end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_steering();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 8'hA5;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL steer_ready: in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
        in_sel  = 1'b1;
        in_data = 8'h3C;
        #3;
        tests_run++;
        if (out0_valid !== 1'b1 || out0_data !== 8'hA5 || out1_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL steer_ch0: v0=%b d0=%h v1=%b, required 1 a5 0", out0_valid, out0_data, out1_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        tests_run++;
        if (out1_valid !== 1'b1 || out1_data !== 8'h3C || out0_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL steer_ch1: v1=%b d1=%h v0=%b, required 1 3c 0", out1_valid, out1_data, out0_valid);
        end
        drain();
    endtask

    task automatic test_full();
        bit ok = 0;
        int start = rx0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(1'b0, 8'h11);
        send(1'b0, 8'h22);
        in_sel = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_ready_sel0: in_ready=%b, required 0", in_ready);
        end
        in_sel = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_ready_sel1: in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 8'h33;
        repeat (3) begin
            #3;
            tests_run++;
            if (in_ready !== 1'b0 || out0_data !== 8'h11) begin
                tests_failed++;
                $display("FAIL full_hold: in_ready=%b head=%h, required 0 11", in_ready, out0_data);
            end
            @(negedge clk);
        end
        out0_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (in_ready === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL full_release: in_ready=%b after out0_ready, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        tests_run++;
        if (rx0 - start !== 3) begin
            tests_failed++;
            $display("FAIL full_count: popped %0d words, required 3", rx0 - start);
        end
    endtask

    task automatic test_simultaneous();
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(1'b0, 8'h44);
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 8'h55;
        out0_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out0_data !== 8'h44) begin
            tests_failed++;
            $display("FAIL simul_pre: in_ready=%b head=%h, required 1 44", in_ready, out0_data);
        end
        @(negedge clk);
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        #3;
        tests_run++;
        if (out0_valid !== 1'b1 || out0_data !== 8'h55) begin
            tests_failed++;
            $display("FAIL simul_head: v0=%b head=%h, required 1 55", out0_valid, out0_data);
        end
        @(negedge clk);
        out0_ready = 1'b1;
        @(negedge clk);
        out0_ready = 1'b0;
        #3;
        tests_run++;
        if (out0_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_occupancy: v0=%b after one pop, required 0", out0_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int start = rx1;
        out0_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send(1'b1, 8'(i));
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out1_ready = (c % 2 == 0);
                    @(negedge clk);
                end
            end
        join
        drain();
        tests_run++;
        if (rx1 - start !== 10) begin
            tests_failed++;
            $display("FAIL wrap_count: received %0d words, required 10", rx1 - start);
        end
    endtask

    task automatic test_reset_mid();
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(1'b0, 8'h66);
        send(1'b1, 8'h77);
        #3;
        tests_run++;
        if (out0_valid !== 1'b1 || out1_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_pre: v0=%b v1=%b, required 1 1", out0_valid, out1_valid);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({in_ready, out0_valid, out1_valid} !== 3'b100 || out0_data !== 8'h00 || out1_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL midrst_state: rdy/v0/v1=%b d0=%h d1=%h, required 100 00 00",
                     {in_ready, out0_valid, out1_valid}, out0_data, out1_data);
        end
`ifdef DEMUX_CNT_EN
        tests_run++;
        if (cnt0 !== 8'h00 || cnt1 !== 8'h00) begin
            tests_failed++;
            $display("FAIL midrst_cnt: cnt0=%h cnt1=%h, required 00 00", cnt0, cnt1);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef DEMUX_CNT_EN
    task automatic test_counters();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 300; i++) send(1'b0, 8'(i));
        for (int i = 0; i < 5; i++) send(1'b1, 8'(i + 8'h80));
        #3;
        tests_run++;
        if (cnt0 !== 8'hFF || cnt1 !== 8'h05) begin
            tests_failed++;
            $display("FAIL cnt_values: cnt0=%h cnt1=%h, required ff 05", cnt0, cnt1);
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_steering();
        test_full();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
`ifdef DEMUX_CNT_EN
        test_counters();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
